mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- Iterative MIPS multiply/divide unit executing MULT, MULTU, DIV and DIVU, and holding the HI/LO architectural registers.
- Sits in the execute stage, directly upstream of the writeback 4:1 result select. Its HI and LO outputs drive two of that select's data inputs, alongside the ALU result and the memory read data.
- The pipeline controller stalls on BUSY and takes the result after DONE.

Parameters:
- N, 32, operand width and width of each of HI and LO.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST_N  input  1  reset, synchronous and active-low.
- START  input  1  launch operation; sampled only when BUSY=0.
- OP  input  2  operation select: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- RS  input  N  multiplicand / dividend.
- RT  input  N  multiplier / divisor.
- MTHI  input  1  write WDATA to HI (idle only).
- MTLO  input  1  write WDATA to LO (idle only).
- WDATA  input  N  data for MTHI/MTLO.
- BUSY  output  1  high while an operation is in flight.
- DONE  output  1  one-cycle pulse when HI/LO have been updated by an operation.
- DIV0  output  1  sticky flag: last divide had RT=0; cleared by the next START.
- HI  output  N  HI register (product upper half / remainder).
- LO  output  N  LO register (product lower half / quotient).

Behaviour:
- Reset: RST_N=0 at an edge forces state IDLE and clears all registers. Outputs: BUSY=0, DONE=0, DIV0=0, HI=0, LO=0. Reset mid-operation aborts the operation, with no partial HI/LO update.
- States: IDLE, CALC, FIX. BUSY = (state != IDLE). DONE is a registered pulse.
- Start (edge E): in IDLE with START=1:
  - capture OP;
  - capture |RS| and |RT| (signed ops take magnitudes; unsigned ops use the raw values);
  - capture the sign of the result and the sign of the remainder;
  - load the iteration counter with N;
  - go to CALC.
- START while BUSY=1 is ignored. START has priority over MTHI/MTLO in the same cycle.
- Divide by zero: a divide with RT=0 at edge E goes IDLE->FIX directly and sets DIV0.
  - At edge E+1: HI=RS (raw), LO={N{1}}, DONE=1.
- CALC: one radix-2 step per edge; the counter decrements.
  - Multiply: shift-add into a 2N-bit accumulator.
  - Divide: restoring shift-subtract, with an N+1-bit remainder compare.
  - At edge E+N the last step completes and the state goes to FIX.
- FIX (edge E+N+1): apply sign correction, load HI/LO, set DONE=1 for one cycle, return to IDLE.
  - Signed multiply: the 2N-bit product is negated when the operand signs differ.
  - Signed divide: the quotient is negated when the signs differ; the remainder takes the sign of the dividend.
- Total latency: N+1 edges from START sampling to HI/LO valid. BUSY is high in cycles E+1..E+N+1 (before edge E+N+1) and low in the DONE cycle.
- Overflow case: DIV of 0x80000000 by 0xFFFFFFFF (N=32) yields LO=0x80000000, HI=0. This falls out of the unsigned magnitude path and needs no trap.
- MTHI/MTLO: honoured only in IDLE with START=0; the register updates at the next edge. Ignored while BUSY. Both asserted together write both registers.
- HI/LO otherwise hold their values, and remain stable during an operation until the FIX edge.

Decomposition:
- Shared package mips_md_pkg holds:
  - the OP encodings MD_MULTU, MD_MULT, MD_DIVU, MD_DIV;
  - the state encodings S_IDLE, S_CALC, S_FIX.
- No sub-module. The conditional-negate helper is a package function reused for operand magnitude and result correction.

Test Plan:
- MULTU RS=0xFFFFFFFF, RT=0xFFFFFFFF, START at E -> BUSY for 33 cycles; at E+33 HI=0xFFFFFFFE, LO=0x00000001, DONE pulse of exactly one cycle.
- MULT RS=0xFFFFFFFD (-3), RT=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB (-21).
- DIV RS=0xFFFFFFF9 (-7), RT=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU RS=7, RT=2 -> LO=3, HI=1.
- DIV RS=0x80000000, RT=0xFFFFFFFF -> LO=0x80000000, HI=0x00000000, DIV0=0.
- DIVU RS=0x1234, RT=0 -> at E+1 DONE=1, HI=0x00001234, LO=0xFFFFFFFF, DIV0=1. Next START clears DIV0.
- Launch MULTU 5*6, then:
  - START with new operands at E+5 -> ignored;
  - MTLO WDATA=0xAA at E+5 -> ignored;
  - result HI=0, LO=30 at E+33;
  - MTHI WDATA=0x55 in idle -> HI=0x55 next edge;
  - RST_N=0 at E'+10 of a new op -> BUSY=0, HI=LO=0, no DONE.

Source files
------------

// File: rtl/mips_md_pkg.sv
// Shared encodings and the conditional-negate helper for the MIPS multiply/divide unit.
package mips_md_pkg;

   localparam int MD_N = 32;

   typedef enum logic [1:0] {
      MD_MULTU = 2'b00,
      MD_MULT  = 2'b01,
      MD_DIVU  = 2'b10,
      MD_DIV   = 2'b11
   } md_op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_CALC = 2'b01,
      S_FIX  = 2'b10
   } md_state_e;

   function automatic logic [MD_N-1:0] cond_neg(input logic [MD_N-1:0] v, input logic neg);
      return neg ? (~v + MD_N'(1)) : v;
   endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Iterative radix-2 MULT/MULTU/DIV/DIVU with HI/LO; N+1 edges START->DONE (1 edge for divide by zero).
// No backpressure: the controller stalls on BUSY, and START/MTHI/MTLO are ignored while busy.
module mult_div_unit
   import mips_md_pkg::*;
#(
   parameter int N = MD_N
) (
   input  logic         CLK,
   input  logic         RST_N,
   input  logic         START,
   input  logic [1:0]   OP,
   input  logic [N-1:0] RS,
   input  logic [N-1:0] RT,
   input  logic         MTHI,
   input  logic         MTLO,
   input  logic [N-1:0] WDATA,
   output logic         BUSY,
   output logic         DONE,
   output logic         DIV0,
   output logic [N-1:0] HI,
   output logic [N-1:0] LO
);

   localparam int CW = $clog2(N + 1);

   md_state_e      state, state_nxt;
   logic           op_div;
   logic           neg_res, neg_rem;
   logic [CW-1:0]  cnt;
   logic [N-1:0]   opnd;
   logic [2*N-1:0] acc;

   logic           in_div, in_signed, rt_zero, s_rs, s_rt;
   logic [N-1:0]   mag_rs, mag_rt;
   logic [N:0]     msum, partial, dsub;
   logic [2*N-1:0] mult_nxt, div_nxt;
   logic [N-1:0]   quo_fix, rem_fix, prod_lo, prod_hi;

   assign in_div    = (OP == MD_DIVU) || (OP == MD_DIV);
   assign in_signed = (OP == MD_MULT) || (OP == MD_DIV);
   assign rt_zero   = (RT == '0);
   assign s_rs      = in_signed & RS[N-1];
   assign s_rt      = in_signed & RT[N-1];
   assign mag_rs    = cond_neg(RS, s_rs);
   assign mag_rt    = cond_neg(RT, s_rt);

   // Multiply: add multiplicand into the upper half when the multiplier LSB is set, then shift right.
   assign msum     = {1'b0, acc[2*N-1:N]} + {1'b0, (acc[0] ? opnd : {N{1'b0}})};
   assign mult_nxt = {msum, acc[N-1:1]};

   // Divide: {remainder, quotient} shifts left; the trial remainder needs N+1 bits for the compare.
   assign partial  = {acc[2*N-1:N], acc[N-1]};
   assign dsub     = partial - {1'b0, opnd};
   assign div_nxt  = (partial >= {1'b0, opnd}) ? {dsub[N-1:0], acc[N-2:0], 1'b1}
                                               : {partial[N-1:0], acc[N-2:0], 1'b0};

   assign quo_fix  = cond_neg(acc[N-1:0], neg_res);
   assign rem_fix  = cond_neg(acc[2*N-1:N], neg_rem);
   // Two's-complement of the 2N-bit product: the carry into the upper half exists only when the lower half is zero.
   assign prod_lo  = cond_neg(acc[N-1:0], neg_res);
   assign prod_hi  = !neg_res ? acc[2*N-1:N]
                   : (acc[N-1:0] == '0) ? cond_neg(acc[2*N-1:N], 1'b1) : ~acc[2*N-1:N];

   assign BUSY = (state != S_IDLE);

   always_ff @(posedge CLK) begin
      if (!RST_N) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (START) state_nxt = (in_div && rt_zero) ? S_FIX : S_CALC;
         S_CALC:  if (cnt == CW'(1)) state_nxt = S_FIX;
         S_FIX:   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         op_div  <= 1'b0;
         neg_res <= 1'b0;
         neg_rem <= 1'b0;
         cnt     <= '0;
         opnd    <= '0;
         acc     <= '0;
         DONE    <= 1'b0;
         DIV0    <= 1'b0;
         HI      <= '0;
         LO      <= '0;
      end else begin
         DONE <= 1'b0;
         case (state)
            S_IDLE: begin
               if (START) begin
                  op_div <= in_div;
                  cnt    <= CW'(N);
                  DIV0   <= in_div & rt_zero;
                  if (in_div && rt_zero) begin
                     // Raw RS lands in HI and all-ones in LO through the unsigned divide path of FIX.
                     neg_res <= 1'b0;
                     neg_rem <= 1'b0;
                     opnd    <= '0;
                     acc     <= {RS, {N{1'b1}}};
                  end else begin
                     neg_res <= s_rs ^ s_rt;
                     neg_rem <= s_rs;
                     opnd    <= in_div ? mag_rt : mag_rs;
                     acc     <= {{N{1'b0}}, (in_div ? mag_rs : mag_rt)};
                  end
               end else begin
                  if (MTHI) HI <= WDATA;
                  if (MTLO) LO <= WDATA;
               end
            end
            S_CALC: begin
               acc <= op_div ? div_nxt : mult_nxt;
               cnt <= cnt - CW'(1);
            end
            S_FIX: begin
               DONE <= 1'b1;
               if (op_div) begin
                  HI <= rem_fix;
                  LO <= quo_fix;
               end else begin
                  HI <= prod_hi;
                  LO <= prod_lo;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed and randomised bench for mult_div_unit; expected results queued at launch, compared at DONE.
module tb_mult_div_unit;
   import mips_md_pkg::*;

   logic        CLK = 1'b0;
   logic        RST_N, START, MTHI, MTLO;
   logic [1:0]  OP;
   logic [31:0] RS, RT, WDATA;
   logic        BUSY, DONE, DIV0;
   logic [31:0] HI, LO;

   typedef struct packed {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        div0;
   } exp_t;

   exp_t sb_q[$];
   int   checks   = 0;
   int   failures = 0;

   mult_div_unit #(.N(32)) dut (
      .CLK(CLK), .RST_N(RST_N), .START(START), .OP(OP), .RS(RS), .RT(RT),
      .MTHI(MTHI), .MTLO(MTLO), .WDATA(WDATA),
      .BUSY(BUSY), .DONE(DONE), .DIV0(DIV0), .HI(HI), .LO(LO)
   );

   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Reference: magnitudes through native * / %, then sign fix-up.
   function automatic logic [64:0] model(input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt);
      logic        sg;
      logic [31:0] ma, mb, q, r;
      logic [63:0] p;
      sg = op[0];
      ma = (sg && rs[31]) ? -rs : rs;
      mb = (sg && rt[31]) ? -rt : rt;
      if (!op[1]) begin
         p = {32'b0, ma} * {32'b0, mb};
         if (sg && (rs[31] ^ rt[31])) p = -p;
         return {1'b0, p};
      end
      if (rt == 32'd0) return {1'b1, rs, 32'hFFFF_FFFF};
      q = ma / mb;
      r = ma % mb;
      if (sg && (rs[31] ^ rt[31])) q = -q;
      if (sg && rs[31]) r = -r;
      return {1'b0, r, q};
   endfunction

   task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt,
                         input logic [31:0] ehi, input logic [31:0] elo, input logic ediv0, input bit poke);
      exp_t        e;
      int          lat, busy_n, exp_lat;
      bit          stable;
      logic [31:0] hi0, lo0;
      sb_q.push_back('{hi: ehi, lo: elo, div0: ediv0});
      exp_lat = (op[1] && rt == 32'd0) ? 1 : 33;
      @(negedge CLK);
      hi0 = HI; lo0 = LO;
      START = 1'b1; OP = op; RS = rs; RT = rt;
      @(negedge CLK);
      START = 1'b0; RS = $urandom; RT = $urandom;
      check($sformatf("%s_div0_launch", tag), {31'b0, DIV0}, {31'b0, ediv0});
      lat = 0; busy_n = 0; stable = 1'b1;
      while (DONE !== 1'b1 && lat < 40) begin
         if (BUSY === 1'b1) busy_n++;
         if (poke && lat == 4) begin
            START = 1'b1; OP = MD_DIVU; RS = 32'd9; RT = 32'd3;
            MTLO = 1'b1; WDATA = 32'h0000_00AA;
         end
         @(negedge CLK);
         lat++;
         START = 1'b0; MTLO = 1'b0;
         if (DONE !== 1'b1 && (HI !== hi0 || LO !== lo0)) stable = 1'b0;
      end
      check($sformatf("%s_latency", tag), 32'(lat), 32'(exp_lat));
      check($sformatf("%s_busy_cycles", tag), 32'(busy_n), 32'(exp_lat));
      check($sformatf("%s_busy_in_done", tag), {31'b0, BUSY}, 32'd0);
      check($sformatf("%s_hilo_hold", tag), {31'b0, stable}, 32'd1);
      check($sformatf("%s_sb_nonempty", tag), 32'(sb_q.size() > 0), 32'd1);
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         check($sformatf("%s_hi", tag), HI, e.hi);
         check($sformatf("%s_lo", tag), LO, e.lo);
         check($sformatf("%s_div0", tag), {31'b0, DIV0}, {31'b0, e.div0});
      end
      @(negedge CLK);
      check($sformatf("%s_done_pulse", tag), {31'b0, DONE}, 32'd0);
   endtask

   initial begin
      logic [1:0]  rop;
      logic [31:0] rrs, rrt;
      logic [64:0] m;
      int          done_seen;

      RST_N = 1'b0; START = 1'b0; OP = '0; RS = '0; RT = '0;
      MTHI = 1'b0; MTLO = 1'b0; WDATA = '0;
      repeat (2) @(negedge CLK);
      check("rst_busy", {31'b0, BUSY}, 32'd0);
      check("rst_done", {31'b0, DONE}, 32'd0);
      check("rst_div0", {31'b0, DIV0}, 32'd0);
      check("rst_hi", HI, 32'd0);
      check("rst_lo", LO, 32'd0);
      RST_N = 1'b1;

      run_op("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b0);
      run_op("mult_neg",  MD_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 1'b0);
      run_op("div_neg",   MD_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0);
      run_op("divu_7_2",  MD_DIVU,  32'd7,         32'd2,         32'd1,         32'd3,         1'b0, 1'b0);
      run_op("div_ovf",   MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 1'b0);
      run_op("divu_zero", MD_DIVU,  32'h0000_1234, 32'd0,         32'h0000_1234, 32'hFFFF_FFFF, 1'b1, 1'b0);
      run_op("multu_poke", MD_MULTU, 32'd5,        32'd6,         32'd0,         32'd30,        1'b0, 1'b1);

      @(negedge CLK);
      MTHI = 1'b1; WDATA = 32'h0000_0055;
      @(negedge CLK);
      MTHI = 1'b0;
      check("mthi_hi", HI, 32'h0000_0055);
      check("mthi_lo_hold", LO, 32'd30);
      MTHI = 1'b1; MTLO = 1'b1; WDATA = 32'h0000_00C3;
      @(negedge CLK);
      MTHI = 1'b0; MTLO = 1'b0;
      check("mtboth_hi", HI, 32'h0000_00C3);
      check("mtboth_lo", LO, 32'h0000_00C3);

      for (int i = 0; i < 8; i++) begin
         rop = 2'($urandom);
         rrs = $urandom;
         rrt = (i == 7) ? 32'd0 : ((i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom);
         if (i % 3 == 0) rrs = rrs >> $urandom_range(0, 24);
         m = model(rop, rrs, rrt);
         run_op($sformatf("rand%0d_op%0d", i, rop), rop, rrs, rrt, m[63:32], m[31:0], m[64], 1'b0);
      end

      run_op("pre_abort", MD_MULTU, 32'd9, 32'd9, 32'd0, 32'd81, 1'b0, 1'b0);
      @(negedge CLK);
      START = 1'b1; OP = MD_MULTU; RS = 32'd3; RT = 32'd4;
      @(negedge CLK);
      START = 1'b0;
      repeat (9) @(negedge CLK);
      check("abort_busy_before", {31'b0, BUSY}, 32'd1);
      RST_N = 1'b0;
      @(negedge CLK);
      check("abort_busy", {31'b0, BUSY}, 32'd0);
      check("abort_done", {31'b0, DONE}, 32'd0);
      check("abort_hi", HI, 32'd0);
      check("abort_lo", LO, 32'd0);
      RST_N = 1'b1;
      done_seen = 0;
      repeat (40) begin
         @(negedge CLK);
         if (DONE === 1'b1) done_seen++;
      end
      check("abort_no_done", 32'(done_seen), 32'd0);
      check("abort_idle", {31'b0, BUSY}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
